// File: rtl/exec_controller.sv
// Run/step/halt sequencer: debounces the board buttons, produces the per-cycle
// datapath execute enable, stops on a breakpoint or HALT word, counts executed
// instructions.
module exec_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] HALT_INSTR      = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_btn,
  input  logic        step_btn,
  input  logic        halt_btn,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic [1:0]  halt_reason,
  output logic [31:0] instr_count
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ReasonNone  = 2'b00;
  localparam logic [1:0] ReasonUser  = 2'b01;
  localparam logic [1:0] ReasonBp    = 2'b10;
  localparam logic [1:0] ReasonInstr = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StStep = 2'b10,
    StHalt = 2'b11
  } state_e;

  // Button conditioning, bit order {halt, step, run}
  logic [2:0]      btn_raw;
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      stable_q, stable_d, stable_prev_q;
  logic [CntW-1:0] cnt_q [3];
  logic [CntW-1:0] cnt_d [3];
  logic [2:0]      btn_pulse;
  logic            run_p, step_p, halt_p;

  state_e      state_q, state_d;
  logic [1:0]  reason_q, reason_d;
  logic        skip_q, skip_d;
  logic [31:0] count_q, count_d;
  logic        halt_instr, bp_hit, stop_now;

  assign btn_raw = {halt_btn, step_btn, run_btn};

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Synchronizer, debounce counters and edge-detect history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q       <= btn_raw;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign btn_pulse = stable_q & ~stable_prev_q;
  assign run_p     = btn_pulse[0];
  assign step_p    = btn_pulse[1];
  assign halt_p    = btn_pulse[2];

  // Stop conditions, execute enable and next-state selection
  always_comb begin
    state_d    = state_q;
    reason_d   = reason_q;
    skip_d     = skip_q;
    halt_instr = (instr == HALT_INSTR);
    // resume_skip lets the instruction at bp_addr run once after a resume
    bp_hit     = bp_en && (pc == bp_addr) && !skip_q;
    stop_now   = halt_instr || bp_hit;
    cpu_en     = ((state_q == StRun) || (state_q == StStep)) && !stop_now && !halt_p;

    unique case (state_q)
      StIdle, StHalt: begin
        // A HALT instruction is sticky; halt_p outranks and drops step/run
        if ((reason_q != ReasonInstr) && !halt_p) begin
          if (step_p) begin
            state_d  = StStep;
            skip_d   = 1'b1;
            reason_d = ReasonNone;
          end else if (run_p) begin
            state_d  = StRun;
            skip_d   = 1'b1;
            reason_d = ReasonNone;
          end
        end
      end
      StRun: begin
        skip_d = 1'b0;
        if (halt_p) begin
          state_d  = StHalt;
          reason_d = ReasonUser;
        end else if (halt_instr) begin
          state_d  = StHalt;
          reason_d = ReasonInstr;
        end else if (bp_hit) begin
          state_d  = StHalt;
          reason_d = ReasonBp;
        end
      end
      StStep: begin
        state_d  = StHalt;
        reason_d = halt_instr ? ReasonInstr : ReasonUser;
        skip_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Saturating executed-instruction counter
  always_comb begin
    count_d = count_q;
    if (cpu_en && (count_q != 32'hFFFF_FFFF)) count_d = count_q + 32'd1;
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      reason_q <= ReasonNone;
      skip_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      reason_q <= reason_d;
      skip_q   <= skip_d;
      count_q  <= count_d;
    end
  end

  assign state       = state_q;
  assign halt_reason = reason_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_exec_controller.sv
// Self-checking bench for exec_controller: behavioural model plus directed and
// randomized button/breakpoint/HALT stimulus.
module tb_exec_controller;

  localparam int unsigned DEB  = 4;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run_btn = 1'b0, step_btn = 1'b0, halt_btn = 1'b0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = '0;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        cpu_en;
  logic [1:0]  state, halt_reason;
  logic [31:0] instr_count;

  logic [31:0] halt_pc = '0;
  logic        halt_pc_en = 1'b0;
  logic        m_load = 1'b0;

  int errors = 0;
  int checks = 0;

  exec_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .HALT_INSTR     (HALT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run_btn    (run_btn),
    .step_btn   (step_btn),
    .halt_btn   (halt_btn),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .instr      (instr),
    .cpu_en     (cpu_en),
    .state      (state),
    .halt_reason(halt_reason),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: a HALT word at halt_pc when enabled, else a harmless word
  assign instr = (halt_pc_en && (pc == halt_pc)) ? HALT : {8'h13, pc[23:0]};

  logic [2:0] raw;
  assign raw = {halt_btn, step_btn, run_btn};

  // ---------------- behavioural model ----------------
  logic [1:0]  m_state, m_reason;
  logic        m_skip;
  logic [31:0] m_count;
  logic [2:0]  m_acc, m_pulse;
  logic [DEB:0] m_hist [3];   // raw samples, bit 0 newest

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_stop();
    return (instr == HALT) || (bp_en && (pc == bp_addr) && !m_skip);
  endfunction

  function automatic logic m_en();
    return reset && ((m_state == 2'b01) || (m_state == 2'b10)) && !m_stop() && !m_pulse[2];
  endfunction

  always @(posedge clk or negedge reset) begin : model_p
    logic en;
    logic [31:0] base;
    logic [DEB+1:0] newh;
    logic accept;
    if (!reset) begin
      m_state  <= 2'b00;
      m_reason <= 2'b00;
      m_skip   <= 1'b0;
      m_count  <= '0;
      m_acc    <= '0;
      m_pulse  <= '0;
      for (int b = 0; b < 3; b++) m_hist[b] <= '0;
      pc <= '0;
    end else begin
      en   = m_en();
      base = m_load ? 32'hFFFF_FFFE : m_count;
      m_count <= (en && base != 32'hFFFF_FFFF) ? base + 32'd1 : base;
      if (en) pc <= pc + 32'd4;
      // Synchronized sample at this edge is the raw level two edges ago
      for (int b = 0; b < 3; b++) begin
        newh   = {m_hist[b], raw[b]};
        accept = (newh[DEB+1:2] == {DEB{~m_acc[b]}});
        m_hist[b]  <= newh[DEB:0];
        m_pulse[b] <= accept && !m_acc[b];
        m_acc[b]   <= accept ? ~m_acc[b] : m_acc[b];
      end
      case (m_state)
        2'b00, 2'b11: begin
          if (m_reason != 2'b11 && !m_pulse[2]) begin
            if (m_pulse[1]) begin
              m_state <= 2'b10; m_skip <= 1'b1; m_reason <= 2'b00;
            end else if (m_pulse[0]) begin
              m_state <= 2'b01; m_skip <= 1'b1; m_reason <= 2'b00;
            end
          end
        end
        2'b01: begin
          m_skip <= 1'b0;
          if (m_pulse[2]) begin
            m_state <= 2'b11; m_reason <= 2'b01;
          end else if (instr == HALT) begin
            m_state <= 2'b11; m_reason <= 2'b11;
          end else if (bp_en && pc == bp_addr && !m_skip) begin
            m_state <= 2'b11; m_reason <= 2'b10;
          end
        end
        default: begin
          m_state  <= 2'b11;
          m_reason <= (instr == HALT) ? 2'b11 : 2'b01;
          m_skip   <= 1'b0;
        end
      endcase
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_cpu_en", 32'(cpu_en), 32'd0);
      chk("rst_state", 32'(state), 32'd0);
    end else begin
      chk("cpu_en", 32'(cpu_en), 32'(m_en()));
      chk("state", 32'(state), 32'(m_state));
      chk("halt_reason", 32'(halt_reason), 32'(m_reason));
      chk("instr_count", instr_count, m_count);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string name);
    int n = 0;
    while (state !== s && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, 32'(state), 32'(s));
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: run_btn = v;
      1: step_btn = v;
      default: halt_btn = v;
    endcase
  endtask

  initial begin
    int ens;
    logic [31:0] base;
    #2 reset = 1'b0;
    tick(3);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_reason", 32'(halt_reason), 32'd0);
    chk("reset_count", instr_count, 32'd0);
    chk("reset_cpu_en", 32'(cpu_en), 32'd0);
    reset = 1'b1;
    tick(2);

    // Run press: RUN exactly 7 cycles after the raw edge, then 20 RUN cycles
    run_btn = 1'b1;
    tick(6);
    chk("run_latency_early", 32'(state), 32'd0);
    tick(1);
    chk("run_latency", 32'(state), 32'd1);
    tick(3);
    run_btn = 1'b0;
    tick(17);
    chk("run20_count", instr_count, 32'd20);
    chk("run20_pc", pc, 32'd80);
    halt_btn = 1'b1;
    wait_state(2'b11, 20, "user_halt_state");
    chk("user_halt_reason", 32'(halt_reason), 32'd1);
    halt_btn = 1'b0;
    tick(DEB + 4);

    // Breakpoint at 0x10, then resume past it
    do_reset();
    bp_en = 1'b1;
    bp_addr = 32'h10;
    run_btn = 1'b1;
    wait_state(2'b11, 40, "bp_state");
    chk("bp_reason", 32'(halt_reason), 32'd2);
    chk("bp_count", instr_count, 32'd4);
    chk("bp_pc", pc, 32'h10);
    run_btn = 1'b0;
    tick(DEB + 4);
    run_btn = 1'b1;
    wait_state(2'b01, 20, "bp_resume_state");
    chk("bp_resume_en", 32'(cpu_en), 32'd1);
    tick(1);
    chk("bp_resume_pc", pc, 32'h14);
    chk("bp_resume_count", instr_count, 32'd5);
    run_btn = 1'b0;
    halt_btn = 1'b1;
    wait_state(2'b11, 20, "bp_halt_state");
    halt_btn = 1'b0;
    tick(DEB + 4);

    // Three single steps
    ens = 0;
    base = m_count;
    for (int s = 0; s < 3; s++) begin
      step_btn = 1'b1;
      for (int c = 0; c < DEB + 6; c++) begin tick(1); if (cpu_en) ens++; end
      step_btn = 1'b0;
      for (int c = 0; c < DEB + 4; c++) begin tick(1); if (cpu_en) ens++; end
      chk("step_state", 32'(state), 32'd3);
      chk("step_reason", 32'(halt_reason), 32'd1);
    end
    chk("step_pulses", 32'(ens), 32'd3);
    chk("step_count", instr_count, base + 32'd3);

    // HALT instruction at 0x8 is sticky
    do_reset();
    bp_en = 1'b0;
    halt_pc = 32'h8;
    halt_pc_en = 1'b1;
    run_btn = 1'b1;
    wait_state(2'b11, 40, "hi_state");
    chk("hi_reason", 32'(halt_reason), 32'd3);
    chk("hi_count", instr_count, 32'd2);
    chk("hi_pc", pc, 32'h8);
    run_btn = 1'b0;
    tick(DEB + 4);
    ens = 0;
    for (int b = 0; b < 2; b++) begin
      set_btn(b, 1'b1);
      for (int c = 0; c < DEB + 6; c++) begin tick(1); if (cpu_en) ens++; end
      set_btn(b, 1'b0);
      for (int c = 0; c < DEB + 4; c++) begin tick(1); if (cpu_en) ens++; end
    end
    chk("hi_no_exec", 32'(ens), 32'd0);
    chk("hi_sticky_state", 32'(state), 32'd3);
    chk("hi_sticky_reason", 32'(halt_reason), 32'd3);
    do_reset();
    halt_pc_en = 1'b0;
    chk("hi_reset_state", 32'(state), 32'd0);

    // Short glitch is ignored
    run_btn = 1'b1;
    tick(2);
    run_btn = 1'b0;
    tick(12);
    chk("glitch_state", 32'(state), 32'd0);

    // halt and run accepted together during RUN: halt wins, run dropped
    run_btn = 1'b1;
    wait_state(2'b01, 20, "run2_state");
    run_btn = 1'b0;
    tick(DEB + 4);
    halt_btn = 1'b1;
    run_btn = 1'b1;
    wait_state(2'b11, 20, "dual_state");
    chk("dual_reason", 32'(halt_reason), 32'd1);
    tick(5);
    chk("dual_stays", 32'(state), 32'd3);
    halt_btn = 1'b0;
    run_btn = 1'b0;
    tick(DEB + 4);

    // Saturation
    @(negedge clk);
    #2 force dut.count_q = 32'hFFFF_FFFE;
    #1 release dut.count_q;
    m_load = 1'b1;
    tick(1);
    m_load = 1'b0;
    chk("sat_preload", instr_count, 32'hFFFF_FFFE);
    run_btn = 1'b1;
    wait_state(2'b01, 20, "sat_run_state");
    tick(3);
    chk("sat_count", instr_count, 32'hFFFF_FFFF);
    run_btn = 1'b0;
    tick(2);
    chk("sat_hold", instr_count, 32'hFFFF_FFFF);
    chk("pre_reset_en", 32'(cpu_en), 32'd1);

    // Async reset mid-RUN
    #1 reset = 1'b0;
    #1;
    chk("async_rst_en", 32'(cpu_en), 32'd0);
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_reason", 32'(halt_reason), 32'd0);
    chk("async_rst_count", instr_count, 32'd0);
    tick(1);
    reset = 1'b1;
    tick(1);

    // Randomized episodes
    for (int ep = 0; ep < 25; ep++) begin
      do_reset();
      bp_en = 1'($urandom_range(0, 1));
      bp_addr = 32'($urandom_range(2, 40)) * 32'd4;
      halt_pc_en = ($urandom_range(0, 3) == 0);
      halt_pc = 32'($urandom_range(3, 60)) * 32'd4;
      for (int a = 0; a < 20; a++) begin
        int b;
        int b2;
        b = int'($urandom_range(0, 2));
        b2 = int'($urandom_range(0, 4));
        set_btn(b, 1'b1);
        if (b2 < 3) set_btn(b2, 1'b1);
        tick(int'($urandom_range(1, 8)));
        run_btn = 1'b0;
        step_btn = 1'b0;
        halt_btn = 1'b0;
        tick(int'($urandom_range(1, 10)));
      end
    end

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
